// File: rtl/wave_pkg.sv
// -----------------------------------------------------------------------------
// wave_pkg
//   Shared definitions for the waveform table loader and its companion RAM.
//   Holds the loader state encoding and the default table geometry used by
//   wave_loader and wave_ram when no parameter override is given.
// -----------------------------------------------------------------------------
package wave_pkg;

    // Default table geometry: 2**WAVE_ADDR_W entries of WAVE_DATA_W bits.
    localparam int WAVE_ADDR_W = 8;
    localparam int WAVE_DATA_W = 8;

    // Loader control states.
    //   IDLE : no load running, table contents not guaranteed
    //   LOAD : accepting samples from upstream and writing them in order
    //   DONE : every entry has been written; the table is readable
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } wave_state_t;

endpackage : wave_pkg

// File: rtl/wave_ram.sv
// -----------------------------------------------------------------------------
// wave_ram
//   Waveform table storage: one synchronous write port fed by wave_loader and
//   two independent synchronous read ports for the playback side. Both read
//   ports have one cycle of latency (address sampled on the rising edge, data
//   valid after it). A read of the address being written in the same cycle
//   returns the old contents.
//
// Ports
//   clk      in   clock, all activity on the rising edge
//   wr_en    in   write strobe
//   wr_addr  in   write address   [ADDRESS_WIDTH-1:0]
//   wr_data  in   write data      [DATA_WIDTH-1:0]
//   addr1    in   read port 1 address
//   dout1    out  read port 1 data, one cycle after addr1
//   addr2    in   read port 2 address
//   dout2    out  read port 2 data, one cycle after addr2
// -----------------------------------------------------------------------------
module wave_ram
    import wave_pkg::*;
#(
    parameter int ADDRESS_WIDTH = WAVE_ADDR_W,
    parameter int DATA_WIDTH    = WAVE_DATA_W
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [ADDRESS_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic [ADDRESS_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0]    dout1,
    input  logic [ADDRESS_WIDTH-1:0] addr2,
    output logic [DATA_WIDTH-1:0]    dout2
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Pure data storage: no reset, so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // ---- read stage p1: registered outputs, one cycle after the address ----
    always_ff @(posedge clk) begin
        dout1 <= mem[addr1];
        dout2 <= mem[addr2];
    end

endmodule : wave_ram

// File: rtl/wave_loader.sv
// -----------------------------------------------------------------------------
// wave_loader
//   Fills a 2**ADDRESS_WIDTH entry waveform table from a valid/ready sample
//   stream. A start request (in IDLE or DONE) clears the address counter and
//   the running checksum and enters LOAD. Each accepted sample is written to
//   the table one cycle later at the next sequential address. The accept at
//   the last address moves the block to DONE, and that final write is
//   presented in the first DONE cycle. abort in LOAD returns to IDLE without
//   accepting that cycle; writes already issued stand.
//
//   The RAM itself lives in wave_ram and is connected at the level above.
//
// Ports
//   clk       in   clock, all state changes on the rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   one-cycle request to begin a full table load
//   abort     in   cancels a load in progress
//   in_valid  in   upstream sample present on in_data
//   in_data   in   upstream sample                     [DATA_WIDTH-1:0]
//   in_ready  out  sample accepted this cycle if in_valid (combinational)
//   wr_en     out  RAM write strobe
//   wr_addr   out  RAM write address                   [ADDRESS_WIDTH-1:0]
//   wr_data   out  RAM write data                      [DATA_WIDTH-1:0]
//   busy      out  high in LOAD
//   done      out  high in DONE, table complete
//   checksum  out  mod-2**DATA_WIDTH sum of samples accepted since last start
// -----------------------------------------------------------------------------
module wave_loader
    import wave_pkg::*;
#(
    parameter int ADDRESS_WIDTH = WAVE_ADDR_W,
    parameter int DATA_WIDTH    = WAVE_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     in_valid,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic                     in_ready,
    output logic                     wr_en,
    output logic [ADDRESS_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_WIDTH-1:0]    checksum
);

    localparam logic [ADDRESS_WIDTH-1:0] CNT_LAST = '1;

    // Modulo-2**DATA_WIDTH accumulate: the carry out is deliberately dropped.
    function automatic logic [DATA_WIDTH-1:0] csum_add(
        input logic [DATA_WIDTH-1:0] acc,
        input logic [DATA_WIDTH-1:0] smp
    );
        return acc + smp;
    endfunction

    wave_state_t              state;
    wave_state_t              state_nxt;
    logic                     restart;
    logic [ADDRESS_WIDTH-1:0] cnt;
    logic [DATA_WIDTH-1:0]    csum;

    logic                     vld_p0;
    logic                     vld_p1;
    logic [ADDRESS_WIDTH-1:0] addr_p1;
    logic [DATA_WIDTH-1:0]    data_p1;

    // ---- stage p0: handshake on the incoming sample ----
    // abort gates ready combinationally so that nothing is accepted in the
    // cycle the load is cancelled.
    assign in_ready = (state == LOAD) && !abort;
    assign vld_p0   = in_valid && in_ready;

    // Next-state logic. start is only honoured outside LOAD; abort is only
    // honoured inside LOAD, so start+abort together in IDLE/DONE is a start.
    always_comb begin
        state_nxt = state;
        restart   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                    restart   = 1'b1;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (vld_p0 && (cnt == CNT_LAST)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_nxt = LOAD;
                    restart   = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Control and tracking state. The write register is reset as well so a
    // reset mid-load kills any pending write immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            csum    <= '0;
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
        end else begin
            state <= state_nxt;

            // restart and vld_p0 are exclusive: restart only occurs outside
            // LOAD, while in_ready is only high inside it.
            if (restart) begin
                cnt  <= '0;
                csum <= '0;
            end else if (vld_p0) begin
                // Wraps to 0 after the last entry, ready for the next load.
                cnt  <= cnt + ADDRESS_WIDTH'(1);
                csum <= csum_add(csum, in_data);
            end

            // ---- stage p1: registered write, fixed one cycle after accept ----
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                addr_p1 <= cnt;
                data_p1 <= in_data;
            end
        end
    end

    assign wr_en    = vld_p1;
    assign wr_addr  = addr_p1;
    assign wr_data  = data_p1;
    assign busy     = (state == LOAD);
    assign done     = (state == DONE);
    assign checksum = csum;

endmodule : wave_loader

// File: tb/tb_wave_loader.sv
// Directed bench for wave_loader with wave_ram connected at this level.
module tb_wave_loader;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;
    logic [DW-1:0] checksum;
    logic [AW-1:0] addr1;
    logic [AW-1:0] addr2;
    logic [DW-1:0] dout1;
    logic [DW-1:0] dout2;

    int total;
    int bad;
    int wr_count;

    wave_loader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .checksum (checksum)
    );

    wave_ram #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .addr1   (addr1),
        .dout1   (dout1),
        .addr2   (addr2),
        .dout2   (dout2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; land 1 time unit after the rising edge and tally writes.
    task automatic tick();
        @(posedge clk);
        #1;
        if (wr_en === 1'b1) wr_count++;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        wr_count = 0;
        start    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        addr1    = '0;
        addr2    = '0;
        rst_n    = 1'b1;
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        #1;
        // Reset state, asynchronous
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_wr_en",    32'(wr_en),    0);
        chk("rst_wr_addr",  32'(wr_addr),  0);
        chk("rst_wr_data",  32'(wr_data),  0);
        chk("rst_busy",     32'(busy),     0);
        chk("rst_done",     32'(done),     0);
        chk("rst_checksum", 32'(checksum), 0);
        tick();
        tick();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 0);
        abort = 1'b1;                       // abort in IDLE is ignored
        tick();
        chk("idle_abort_busy", 32'(busy), 0);
        abort = 1'b0;

        // Back-to-back load 0x00..0x0F
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b_busy", 32'(busy), 1);
        chk("b2b_wr_en_idle", 32'(wr_en), 0);
        wr_count = 0;
        in_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            in_data = 8'(k);
            chk($sformatf("b2b_ready%0d", k), 32'(in_ready), 1);
            tick();
            chk($sformatf("b2b_wr_en%0d", k), 32'(wr_en),   1);
            chk($sformatf("b2b_addr%0d", k),  32'(wr_addr), 32'(k));
            chk($sformatf("b2b_data%0d", k),  32'(wr_data), 32'(k));
            chk($sformatf("b2b_done%0d", k),  32'(done),    (k == 15) ? 1 : 0);
        end
        in_valid = 1'b0;
        chk("b2b_ready_done", 32'(in_ready), 0);
        tick();
        chk("b2b_wr_en_after", 32'(wr_en), 0);
        chk("b2b_done_hold", 32'(done), 1);
        chk("b2b_checksum", 32'(checksum), 32'h78);
        chk("b2b_count", 32'(wr_count), 16);
        addr1 = 4'd3;
        addr2 = 4'd15;
        tick();
        chk("ram_dout1", 32'(dout1), 3);
        chk("ram_dout2", 32'(dout2), 15);

        // Stalled load: in_valid low every other cycle; start from DONE
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("stall_busy", 32'(busy), 1);
        chk("stall_done", 32'(done), 0);
        chk("stall_csum_clr", 32'(checksum), 0);
        wr_count = 0;
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(k);
            tick();
            chk($sformatf("stall_wr_en%0d", k), 32'(wr_en),   1);
            chk($sformatf("stall_addr%0d", k),  32'(wr_addr), 32'(k));
            chk($sformatf("stall_data%0d", k),  32'(wr_data), 32'(k));
            in_valid = 1'b0;
            in_data  = 8'hAA;
            tick();
            chk($sformatf("stall_gap%0d", k), 32'(wr_en), 0);
        end
        chk("stall_done_end", 32'(done), 1);
        chk("stall_checksum", 32'(checksum), 32'h78);
        chk("stall_count", 32'(wr_count), 16);

        // Abort after 5 accepts
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_count = 0;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_data = 8'(8'h10 + k);
            tick();
            chk($sformatf("abort_addr%0d", k), 32'(wr_addr), 32'(k));
            chk($sformatf("abort_data%0d", k), 32'(wr_data), 32'(8'h10 + k));
        end
        abort   = 1'b1;
        in_data = 8'h55;
        #1;
        chk("abort_ready", 32'(in_ready), 0);
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("abort_wr_en", 32'(wr_en), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_checksum", 32'(checksum), 32'h5A);
        tick();
        chk("abort_count", 32'(wr_count), 5);

        // start together with abort in IDLE is a start
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("restart_busy", 32'(busy), 1);
        chk("restart_csum", 32'(checksum), 0);
        wr_count = 0;
        in_valid = 1'b1;
        in_data  = 8'h33;
        tick();
        chk("restart_addr", 32'(wr_addr), 0);
        chk("restart_data", 32'(wr_data), 32'h33);
        chk("restart_csum1", 32'(checksum), 32'h33);

        // Reset mid-load after 7 accepts
        for (int k = 1; k < 7; k++) begin
            in_data = 8'(k);
            tick();
            chk($sformatf("rml_addr%0d", k), 32'(wr_addr), 32'(k));
        end
        chk("rml_count", 32'(wr_count), 7);
        chk("rml_wr_en_pre", 32'(wr_en), 1);
        rst_n = 1'b0;
        #1;
        chk("rml_wr_en",    32'(wr_en),    0);
        chk("rml_wr_addr",  32'(wr_addr),  0);
        chk("rml_wr_data",  32'(wr_data),  0);
        chk("rml_in_ready", 32'(in_ready), 0);
        chk("rml_busy",     32'(busy),     0);
        chk("rml_checksum", 32'(checksum), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rml_count_post", 32'(wr_count), 7);
        chk("rml_idle", 32'(busy), 0);
        in_valid = 1'b0;

        // Checksum wrap with 0xFF; start mid-load is ignored
        start = 1'b1;
        tick();
        in_valid = 1'b1;
        in_data  = 8'hFF;
        for (int k = 0; k < 16; k++) begin
            start = (k == 8);
            tick();
            chk($sformatf("wrap_addr%0d", k), 32'(wr_addr), 32'(k));
        end
        start    = 1'b0;
        in_valid = 1'b0;
        chk("wrap_done", 32'(done), 1);
        chk("wrap_checksum", 32'(checksum), 32'hF0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("wrap_restart_busy", 32'(busy), 1);
        chk("wrap_restart_done", 32'(done), 0);
        chk("wrap_restart_csum", 32'(checksum), 0);
        in_valid = 1'b1;
        in_data  = 8'h07;
        tick();
        in_valid = 1'b0;
        chk("wrap_restart_addr", 32'(wr_addr), 0);
        chk("wrap_restart_data", 32'(wr_data), 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_wave_loader

// File: doc/wave_loader.md
WAVE_LOADER -- requirements
Module: wave_loader

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 8: table depth is 2**ADDRESS_WIDTH entries.
REQ-002 Parameter DATA_WIDTH, default 8: width of one table entry.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a full table load.
REQ-006 abort  input  1  cancels a load in progress.
REQ-007 in_valid  input  1  upstream sample present on in_data.
REQ-008 in_data  input  DATA_WIDTH  upstream table sample.
REQ-009 in_ready  output  1  block accepts in_data this cycle.
REQ-010 wr_en  output  1  write strobe to the RAM write port.
REQ-011 wr_addr  output  ADDRESS_WIDTH  RAM write address.
REQ-012 wr_data  output  DATA_WIDTH  RAM write data.
REQ-013 busy  output  1  high in LOAD.
REQ-014 done  output  1  high in DONE; the table is complete and readable.
REQ-015 checksum  output  DATA_WIDTH  modulo-2**DATA_WIDTH sum of all samples accepted since the last start.

Function
REQ-016 The FSM SHALL have three states: IDLE, LOAD and DONE.
REQ-017 The FSM SHALL go IDLE->LOAD or DONE->LOAD on start, clearing the address counter and checksum to 0.
REQ-018 start SHALL be ignored while in LOAD.
REQ-019 in_ready SHALL equal (state==LOAD) && !abort, combinationally.
REQ-020 Accept SHALL be defined as in_valid && in_ready, sampled on the rising edge.
REQ-021 On accept, the next cycle SHALL drive wr_en=1, wr_addr=current counter and wr_data=in_data (fixed 1-cycle latency); otherwise wr_en=0.
REQ-022 On accept, the counter SHALL increment by 1 and checksum SHALL become checksum+in_data, truncated to DATA_WIDTH.
REQ-023 The accept at counter 2**ADDRESS_WIDTH-1 SHALL move the FSM to DONE; the counter wraps to 0, and that last write appears in the first DONE cycle.
REQ-024 in_valid gaps in LOAD SHALL stall the load with no write and no counter change.
REQ-025 abort in LOAD SHALL force IDLE on the next edge with no accept that cycle; writes already issued stand; done stays 0; checksum holds its partial value.
REQ-026 abort SHALL be ignored in IDLE and DONE; start and abort together in IDLE or DONE SHALL be treated as start.
REQ-027 The block SHALL never assert wr_en more than 2**ADDRESS_WIDTH times per load.
REQ-028 The block SHALL never write the same address twice per load.

Reset
REQ-029 While rst_n=0 the block SHALL be in IDLE with counter=0, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0 and checksum=0, asynchronously.
REQ-030 A reset asserted mid-load SHALL drop any pending write (wr_en=0 immediately); the table is then treated as invalid until a new full load.

Structure
REQ-031 A shared package wave_pkg SHALL hold the state enum (IDLE, LOAD, DONE) and default width constants.
REQ-032 The companion storage SHALL be a separate sub-module wave_ram: one synchronous write port (wr_en, wr_addr, wr_data) and two synchronous read ports (addr1/dout1, addr2/dout2) with 1-cycle read latency.
REQ-033 wave_loader SHALL NOT instantiate wave_ram; the top level connects them.

Verification (ADDRESS_WIDTH=4, DATA_WIDTH=8)
REQ-034 Back-to-back load: start, then in_data=0x00..0x0F with in_valid held high -> 16 writes, addr n carries data n, each one cycle after accept; done=1 after the write to addr 15; checksum=0x78.
REQ-035 Stalls: the same data with in_valid low on every other cycle -> identical write sequence, spread over 32 cycles; no wr_en during gaps.
REQ-036 Abort: abort after 5 accepts -> exactly 5 writes (addr 0-4); state IDLE; done=0; in_ready=0 in the abort cycle; a later start restarts at addr 0 with checksum 0.
REQ-037 Reset mid-load: rst_n low after 7 accepts -> all outputs 0 within the same cycle; no further wr_en.
REQ-038 Checksum wrap: 16 samples of 0xFF -> checksum=0xF0; a start while in LOAD is ignored (no counter reset); a start in DONE restarts the load.
